// File: rtl/tqv_periph_initiator.sv
// TinyQV peripheral bus initiator. It takes one command, runs one strobe transaction on the
// peripheral bus, and returns one response. Reads are abandoned after TIMEOUT_CYCLES strobe cycles.
//   state | meaning
//   IDLE  | waiting for a command
//   WRITE | single posted write strobe cycle
//   READ  | read strobe held until periph_ready or timeout
//   RESP  | response held until rsp_ready
module tqv_periph_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [1:0]       cmd_size,
  input  logic [5:0]       cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic [5:0]       periph_address,
  output logic [31:0]      periph_wdata,
  output logic [1:0]       periph_write_n,
  output logic [1:0]       periph_read_n,
  input  logic [31:0]      periph_rdata,
  input  logic             periph_ready,
  output logic [CNT_W-1:0] stat_done,
  output logic [CNT_W-1:0] stat_timeout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_SIZE    = 2'b10;
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [5:0]  address_d;
  logic [31:0] wdata_d;
  logic [1:0]  write_n_d, read_n_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic [1:0]  rsp_err_d;
  logic        done_inc, timeout_inc;
  logic [31:0] rdata_masked;

  always_comb begin
    case (size_q)
      2'b00:   rdata_masked = {24'h0, periph_rdata[7:0]};
      2'b01:   rdata_masked = {16'h0, periph_rdata[15:0]};
      default: rdata_masked = periph_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    to_cnt_d    = to_cnt_q;
    address_d   = periph_address;
    wdata_d     = '0;
    write_n_d   = 2'b11;
    read_n_d    = 2'b11;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    done_inc    = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          size_d   = cmd_size;
          to_cnt_d = '0;
          // Illegal size never touches the bus; answer straight away.
          if (cmd_size == 2'b11) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = ERR_SIZE;
          end else if (cmd_write) begin
            state_d   = WRITE;
            address_d = cmd_addr;
            wdata_d   = cmd_wdata;
            write_n_d = cmd_size;
          end else begin
            state_d   = READ;
            address_d = cmd_addr;
            read_n_d  = cmd_size;
          end
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = ERR_OK;
      end
      READ: begin
        if (periph_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_masked;
          rsp_err_d   = ERR_OK;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_TIMEOUT;
          timeout_inc = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          read_n_d = size_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          done_inc = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      size_q         <= '0;
      to_cnt_q       <= '0;
      cmd_ready      <= 1'b0;
      periph_address <= '0;
      periph_wdata   <= '0;
      periph_write_n <= 2'b11;
      periph_read_n  <= 2'b11;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= '0;
      stat_done      <= '0;
      stat_timeout   <= '0;
    end else begin
      state_q        <= state_d;
      size_q         <= size_d;
      to_cnt_q       <= to_cnt_d;
      cmd_ready      <= (state_d == IDLE);
      periph_address <= address_d;
      periph_wdata   <= wdata_d;
      periph_write_n <= write_n_d;
      periph_read_n  <= read_n_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_err        <= rsp_err_d;
      if (done_inc && (stat_done != '1))
        stat_done <= stat_done + CNT_W'(1);
      if (timeout_inc && (stat_timeout != '1))
        stat_timeout <= stat_timeout + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tqv_periph_initiator.sv
// Bench for tqv_periph_initiator: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_tqv_periph_initiator;

  localparam int T     = 16;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_size;
  logic [5:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [5:0] periph_address;
  logic [31:0] periph_wdata;
  logic [1:0] periph_write_n, periph_read_n;
  logic [31:0] periph_rdata;
  logic periph_ready;
  logic [CNT_W-1:0] stat_done, stat_timeout;

  tqv_periph_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .periph_address(periph_address), .periph_wdata(periph_wdata),
    .periph_write_n(periph_write_n), .periph_read_n(periph_read_n),
    .periph_rdata(periph_rdata), .periph_ready(periph_ready),
    .stat_done(stat_done), .stat_timeout(stat_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [31:0] prd;
    int          ra;      // read cycle in which periph_ready rises, 0 = never
    int          dly;     // cycles of rsp_ready low once rsp_valid is seen
    bit          bp;      // present another cmd_valid during the response stall
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    int          e_lat;
    int          e_ws;
    int          e_rs;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int m_done = 0;
  int m_to = 0;

  int o_lat, o_ws, o_rs, o_inv_bad, o_stable_bad;
  logic [31:0] o_rdata, o_wd;
  logic [1:0] o_err, o_code;
  logic [5:0] o_addr;
  logic o_rdy_after, o_valid_after;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input bit wr, input logic [1:0] sz, input logic [31:0] prd,
                                input int ra, output logic [31:0] rd, output logic [1:0] er,
                                output int lat, output int ws, output int rs, output bit to);
    rd = '0; er = 2'b00; ws = 0; rs = 0; to = 1'b0; lat = 0;
    if (sz == 2'b11) begin
      er = 2'b10; lat = 1;
    end else if (wr) begin
      ws = 1; lat = 2;
    end else if (ra >= 1 && ra <= T) begin
      rs = ra; lat = ra + 1;
      if (sz == 2'b00) rd = prd & 32'h0000_00FF;
      else if (sz == 2'b01) rd = prd & 32'h0000_FFFF;
      else rd = prd;
    end else begin
      rs = T; lat = T + 1; er = 2'b01; to = 1'b1;
    end
  endfunction

  task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [31:0] prd, input int ra,
                         input int dly, input bit bp);
    int n;
    logic [31:0] held_rd;
    logic [1:0] held_er;
    o_lat = 0; o_ws = 0; o_rs = 0; o_inv_bad = 0; o_stable_bad = 0;
    o_rdata = '0; o_err = '0; o_code = 2'b11; o_addr = '0; o_wd = '0;
    o_rdy_after = 1'b0; o_valid_after = 1'b1;
    cmd_write = wr; cmd_size = sz; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_accept_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      periph_rdata = prd;
      periph_ready = (ra != 0 && c >= ra);
      if (periph_write_n != 2'b11 && periph_read_n != 2'b11) o_inv_bad++;
      if (rsp_valid && (periph_write_n != 2'b11 || periph_read_n != 2'b11)) o_inv_bad++;
      if (periph_write_n != 2'b11) begin
        o_ws++; o_code = periph_write_n; o_addr = periph_address; o_wd = periph_wdata;
      end
      if (periph_read_n != 2'b11) begin
        o_rs++; o_code = periph_read_n; o_addr = periph_address;
        if (periph_wdata != 32'h0) o_inv_bad++;
      end
      if (rsp_valid) begin
        o_lat = c;
        break;
      end
      tick();
    end
    periph_ready = 1'b0;
    if (o_lat != 0) begin
      o_rdata = rsp_rdata; o_err = rsp_err;
      held_rd = rsp_rdata; held_er = rsp_err;
      if (cmd_ready) o_stable_bad++;
      for (int i = 0; i < dly; i++) begin
        cmd_valid = bp;
        tick();
        if (!rsp_valid || rsp_rdata !== held_rd || rsp_err !== held_er || cmd_ready)
          o_stable_bad++;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      o_rdy_after = cmd_ready;
      o_valid_after = rsp_valid;
    end
  endtask

  task automatic check_txn(input string tag, input logic [1:0] sz, input logic [5:0] addr,
                           input logic [31:0] wd, input int dly, input logic [31:0] e_rd,
                           input logic [1:0] e_er, input int e_lat, input int e_ws, input int e_rs);
    chk({tag, " latency"}, 32'(o_lat), 32'(e_lat));
    chk({tag, " write_strobes"}, 32'(o_ws), 32'(e_ws));
    chk({tag, " read_strobes"}, 32'(o_rs), 32'(e_rs));
    chk({tag, " rsp_rdata"}, o_rdata, e_rd);
    chk({tag, " rsp_err"}, 32'(o_err), 32'(e_er));
    if (e_ws + e_rs > 0) begin
      chk({tag, " strobe_code"}, 32'(o_code), 32'(sz));
      chk({tag, " periph_address"}, 32'(o_addr), 32'(addr));
    end
    if (e_ws > 0) chk({tag, " periph_wdata"}, o_wd, wd);
    chk({tag, " invariants"}, 32'(o_inv_bad), 32'd0);
    if (dly > 0) chk({tag, " rsp_stable"}, 32'(o_stable_bad), 32'd0);
    chk({tag, " rsp_valid_drop"}, 32'(o_valid_after), 32'd0);
    chk({tag, " cmd_ready_after"}, 32'(o_rdy_after), 32'd1);
    if (m_done < SAT) m_done++;
    if (e_er == 2'b01 && m_to < SAT) m_to++;
    chk({tag, " stat_done"}, 32'(stat_done), 32'(m_done));
    chk({tag, " stat_timeout"}, 32'(stat_timeout), 32'(m_to));
  endtask

  vec_t tbl[11];
  int acc[8];
  int n_acc;
  int bad;

  initial begin
    tbl[0]  = '{1'b1, 2'b10, 6'h00, 32'hE000001F, 32'h0,        0,  0, 1'b0, 32'h0,        2'b00, 2,  1, 0};
    tbl[1]  = '{1'b0, 2'b00, 6'h28, 32'h0,        32'hA5A51234, 1,  0, 1'b0, 32'h00000034, 2'b00, 2,  0, 1};
    tbl[2]  = '{1'b0, 2'b01, 6'h28, 32'h0,        32'hA5A51234, 1,  0, 1'b0, 32'h00001234, 2'b00, 2,  0, 1};
    tbl[3]  = '{1'b0, 2'b10, 6'h28, 32'h0,        32'hA5A51234, 1,  2, 1'b0, 32'hA5A51234, 2'b00, 2,  0, 1};
    tbl[4]  = '{1'b0, 2'b10, 6'h28, 32'h0,        32'hA5A51234, 0,  0, 1'b0, 32'h0,        2'b01, 17, 0, 16};
    tbl[5]  = '{1'b0, 2'b10, 6'h28, 32'h0,        32'hA5A51234, 16, 0, 1'b0, 32'hA5A51234, 2'b00, 17, 0, 16};
    tbl[6]  = '{1'b0, 2'b00, 6'h15, 32'h0,        32'hDEADBEEF, 5,  1, 1'b0, 32'h000000EF, 2'b00, 6,  0, 5};
    tbl[7]  = '{1'b1, 2'b11, 6'h01, 32'hFFFFFFFF, 32'h0,        0,  0, 1'b0, 32'h0,        2'b10, 1,  0, 0};
    tbl[8]  = '{1'b0, 2'b11, 6'h02, 32'h0,        32'h12345678, 1,  0, 1'b0, 32'h0,        2'b10, 1,  0, 0};
    tbl[9]  = '{1'b1, 2'b00, 6'h3F, 32'h12345678, 32'h0,        0,  10, 1'b1, 32'h0,       2'b00, 2,  1, 0};
    tbl[10] = '{1'b0, 2'b01, 6'h07, 32'h0,        32'h0000BEEF, 3,  4, 1'b1, 32'h0000BEEF, 2'b00, 4,  0, 3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; periph_rdata = '0; periph_ready = 1'b0;
    tick(); tick(); tick();
    chk("reset write_n", 32'(periph_write_n), 32'h3);
    chk("reset read_n", 32'(periph_read_n), 32'h3);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'h0);
    chk("reset address", 32'(periph_address), 32'h0);
    chk("reset wdata", periph_wdata, 32'h0);
    chk("reset rdata_err", {rsp_rdata[29:0], rsp_err}, 32'h0);
    chk("reset stats", 32'({stat_done, stat_timeout}), 32'h0);
    rst = 1'b0;
    tick();
    chk("cmd_ready after reset", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].prd, tbl[i].ra,
              tbl[i].dly, tbl[i].bp);
      check_txn($sformatf("vec%0d", i), tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].dly,
                tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_ws, tbl[i].e_rs);
    end

    // Back-to-back posted writes with rsp_ready tied high.
    n_acc = 0;
    cmd_write = 1'b1; cmd_size = 2'b10; cmd_addr = 6'h04; cmd_wdata = 32'hCAFE0001;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cmd_valid && cmd_ready && n_acc < 8) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b accept count", 32'(n_acc), 32'd4);
    if (n_acc >= 4) begin
      chk("b2b first gap", 32'(acc[1] - acc[0]), 32'd3);
      chk("b2b last gap", 32'(acc[3] - acc[2]), 32'd3);
    end
    for (int i = 0; i < 4; i++) if (m_done < SAT) m_done++;
    tick();
    chk("b2b stat_done", 32'(stat_done), 32'(m_done));

    for (int i = 0; i < 40; i++) begin
      bit wr, to, bp;
      logic [1:0] sz, e_er;
      logic [5:0] ad;
      logic [31:0] wd, prd, e_rd;
      int ra, dly, e_lat, e_ws, e_rs;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 6'($urandom);
      wd = $urandom;
      prd = $urandom;
      ra = $urandom_range(0, 18);
      dly = $urandom_range(0, 3);
      bp = 1'($urandom_range(0, 1));
      model(wr, sz, prd, ra, e_rd, e_er, e_lat, e_ws, e_rs, to);
      run_txn(wr, sz, ad, wd, prd, ra, dly, bp);
      check_txn($sformatf("rnd%0d", i), sz, ad, wd, dly, e_rd, e_er, e_lat, e_ws, e_rs);
    end

    // Reset while a read is stalled in its third strobe cycle.
    cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'h28; cmd_valid = 1'b1;
    periph_ready = 1'b0;
    for (int n = 0; n < 20 && !cmd_ready; n++) tick();
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("midreset read strobe", 32'(periph_read_n), 32'h2);
    rst = 1'b1;
    tick();
    chk("midreset read_n", 32'(periph_read_n), 32'h3);
    chk("midreset write_n", 32'(periph_write_n), 32'h3);
    chk("midreset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midreset stat_done", 32'(stat_done), 32'h0);
    chk("midreset stat_timeout", 32'(stat_timeout), 32'h0);
    rst = 1'b0;
    tick();
    chk("midreset cmd_ready", 32'(cmd_ready), 32'h1);
    bad = 0;
    for (int n = 0; n < 24; n++) begin
      if (rsp_valid || periph_read_n != 2'b11 || periph_write_n != 2'b11) bad++;
      tick();
    end
    chk("midreset no response", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
